// File: rtl/mtpsa_user_arbiter.sv
// Packet-granular round-robin arbiter sharing one user pipeline AXIS port among
// NUM_USERS tenant streams, with a per-tenant enable mask and packet counters.
module mtpsa_user_arbiter #(
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_USERS          = 4,
   parameter int USER_ID_WIDTH      = 2,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                                        axis_aclk,
   input  logic                                        axis_resetn,
   input  logic [NUM_USERS*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [NUM_USERS*C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
   input  logic [NUM_USERS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic [NUM_USERS-1:0]                        s_axis_tvalid,
   output logic [NUM_USERS-1:0]                        s_axis_tready,
   input  logic [NUM_USERS-1:0]                        s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
   output logic                                        m_axis_tvalid,
   input  logic                                        m_axis_tready,
   output logic                                        m_axis_tlast,
   input  logic [NUM_USERS-1:0]                        user_enable,
   output logic                                        busy,
   output logic [USER_ID_WIDTH-1:0]                    cur_user,
   output logic [NUM_USERS*CNT_WIDTH-1:0]              pkt_cnt
);

   localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                   state, state_nxt;
   logic [USER_ID_WIDTH-1:0] grant, grant_nxt;
   logic [USER_ID_WIDTH-1:0] last_grant, last_grant_nxt;
   logic [USER_ID_WIDTH-1:0] pick, idx;
   logic                     pick_valid;
   logic [NUM_USERS-1:0]     req;
   logic                     pkt_done;
   logic [CNT_WIDTH-1:0]     cnt [NUM_USERS];

   assign req = s_axis_tvalid & user_enable;

   // Round-robin search starting just after the previous winner, wrapping at NUM_USERS.
   // NOTE: combinational blocks use blocking '=' and assign every output before any
   // branch, so no latch is inferred; clocked blocks use '<=' only.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      idx        = last_grant;
      for (int k = 0; k < NUM_USERS; k++) begin
         idx = (idx == USER_ID_WIDTH'(NUM_USERS - 1)) ? '0 : idx + 1'b1;
         if (!pick_valid && req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   // Output mux is driven from the registered grant; only valid/last/ready are qualified.
   always_comb begin
      m_axis_tdata  = s_axis_tdata[int'(grant)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
      m_axis_tkeep  = s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tuser  = s_axis_tuser[int'(grant)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state == BUSY) begin
         m_axis_tvalid = s_axis_tvalid[grant];
         m_axis_tlast  = s_axis_tlast[grant];
         s_axis_tready = NUM_USERS'(m_axis_tready) << grant;
      end
   end

   assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;
   assign busy     = (state == BUSY);
   assign cur_user = grant;

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_nxt      = pick;
               last_grant_nxt = pick;
               state_nxt      = BUSY;
            end
         end
         BUSY: begin
            if (pkt_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= USER_ID_WIDTH'(NUM_USERS - 1);
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // NOTE: the counter array is reset explicitly because the control plane reads it
   // directly; it is a handful of registers, not a RAM.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         for (int i = 0; i < NUM_USERS; i++) cnt[i] <= '0;
      end else if (pkt_done) begin
         cnt[grant] <= cnt[grant] + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_USERS; i++) begin : g_cnt
      assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
   end

endmodule

// File: tb/tb_mtpsa_user_arbiter.sv
// Randomized bench for mtpsa_user_arbiter against a packet-level round-robin model.
module tb_mtpsa_user_arbiter;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int TW = 128;
   localparam int IW = 2;
   localparam int CW = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N*DW-1:0]   s_tdata = '0;
   logic [N*KW-1:0]   s_tkeep = '0;
   logic [N*TW-1:0]   s_tuser = '0;
   logic [N-1:0]      s_tvalid = '0;
   logic [N-1:0]      s_tready;
   logic [N-1:0]      s_tlast = '0;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic [TW-1:0]     m_tuser;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
   logic              m_tlast;
   logic [N-1:0]      user_enable = '0;
   logic              busy;
   logic [IW-1:0]     cur_user;
   logic [N*CW-1:0]   pkt_cnt;

   always #5 clk = ~clk;

   mtpsa_user_arbiter #(
      .C_AXIS_DATA_WIDTH (DW),
      .C_AXIS_TUSER_WIDTH(TW),
      .NUM_USERS         (N),
      .USER_ID_WIDTH     (IW),
      .CNT_WIDTH         (CW)
   ) dut (
      .axis_aclk    (clk),
      .axis_resetn  (rst_n),
      .s_axis_tdata (s_tdata),
      .s_axis_tkeep (s_tkeep),
      .s_axis_tuser (s_tuser),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tlast (s_tlast),
      .m_axis_tdata (m_tdata),
      .m_axis_tkeep (m_tkeep),
      .m_axis_tuser (m_tuser),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tlast (m_tlast),
      .user_enable  (user_enable),
      .busy         (busy),
      .cur_user     (cur_user),
      .pkt_cnt      (pkt_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: packet-level grant bookkeeping with plain integers.
   bit m_busy;
   int m_grant, m_last;
   int m_cnt[N];

   task automatic model_reset();
      m_busy  = 1'b0;
      m_grant = 0;
      m_last  = N - 1;
      for (int u = 0; u < N; u++) m_cnt[u] = 0;
   endtask

   // Stimulus sources: each user walks through packets of random length.
   int rem[N];
   int p_valid = 100, p_ready = 100, fixed_len = 0;
   int en_mode = 0;            // 0: all enabled, 1: fixed 4'b1010, 2: random each cycle
   bit rec_grants = 1'b0;
   bit prev_busy = 1'b0;
   int grants[$];

   task automatic new_beat(input int u);
      for (int w = 0; w < DW / 32; w++) s_tdata[u*DW + w*32 +: 32] = $urandom;
      for (int w = 0; w < TW / 32; w++) s_tuser[u*TW + w*32 +: 32] = $urandom;
      s_tkeep[u*KW +: KW] = $urandom;
      s_tlast[u] = (rem[u] == 1);
   endtask

   task automatic new_packet(input int u);
      rem[u] = (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 5));
      new_beat(u);
   endtask

   task automatic drive_controls();
      for (int u = 0; u < N; u++) s_tvalid[u] = ($urandom_range(0, 99) < p_valid);
      m_tready = ($urandom_range(0, 99) < p_ready);
      case (en_mode)
         0:       user_enable = '1;
         1:       user_enable = 4'b1010;
         default: user_enable = N'($urandom);
      endcase
   endtask

   task automatic check_outputs();
      logic [N-1:0]    exp_rdy;
      logic [N*CW-1:0] exp_cnt;
      exp_rdy = m_busy ? (N'(m_tready) << m_grant) : '0;
      for (int u = 0; u < N; u++) exp_cnt[u*CW +: CW] = CW'(m_cnt[u]);
      check("m_tvalid", DW'(m_tvalid), DW'(m_busy ? s_tvalid[m_grant] : 1'b0));
      check("m_tlast",  DW'(m_tlast),  DW'(m_busy ? s_tlast[m_grant] : 1'b0));
      check("m_tdata",  m_tdata,       s_tdata[m_grant*DW +: DW]);
      check("m_tkeep",  DW'(m_tkeep),  DW'(s_tkeep[m_grant*KW +: KW]));
      check("m_tuser",  DW'(m_tuser),  DW'(s_tuser[m_grant*TW +: TW]));
      check("s_tready", DW'(s_tready), DW'(exp_rdy));
      check("busy",     DW'(busy),     DW'(m_busy));
      check("cur_user", DW'(cur_user), DW'(m_grant));
      check("pkt_cnt",  DW'(pkt_cnt),  DW'(exp_cnt));
   endtask

   // One clock: compare at negedge, advance the model at posedge, drive new inputs after.
   task automatic step();
      logic [N-1:0] fire;
      logic [N-1:0] req;
      @(negedge clk);
      check_outputs();
      if (rec_grants && busy && !prev_busy) grants.push_back(int'(cur_user));
      prev_busy = busy;
      fire = '0;
      if (m_busy && s_tvalid[m_grant] && m_tready) fire[m_grant] = 1'b1;
      req = s_tvalid & user_enable;
      @(posedge clk);
      if (!m_busy) begin
         for (int k = 1; k <= N && !m_busy; k++) begin
            if (req[(m_last + k) % N]) begin
               m_grant = (m_last + k) % N;
               m_last  = m_grant;
               m_busy  = 1'b1;
            end
         end
      end else if (fire[m_grant] && s_tlast[m_grant]) begin
         m_cnt[m_grant] = (m_cnt[m_grant] + 1) % (1 << CW);
         m_busy = 1'b0;
      end
      #1;
      for (int u = 0; u < N; u++) begin
         if (fire[u]) begin
            if (rem[u] == 1) new_packet(u);
            else begin
               rem[u]--;
               new_beat(u);
            end
         end
      end
      drive_controls();
   endtask

   initial begin
      model_reset();
      for (int u = 0; u < N; u++) new_packet(u);
      drive_controls();
      #23;
      // Reset state, with every user requesting.
      check("rst_busy",     DW'(busy),     DW'(1'b0));
      check("rst_m_tvalid", DW'(m_tvalid), DW'(1'b0));
      check("rst_s_tready", DW'(s_tready), DW'(0));
      check("rst_cur_user", DW'(cur_user), DW'(0));
      check("rst_pkt_cnt",  DW'(pkt_cnt),  DW'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fairness: continuous 2-beat packets from all users, sink always ready.
      fixed_len = 2;
      for (int u = 0; u < N; u++) new_packet(u);
      p_valid = 100; p_ready = 100; en_mode = 0;
      drive_controls();
      rec_grants = 1'b1;
      for (int c = 0; c < 24; c++) step();
      rec_grants = 1'b0;
      check("fair_count", DW'(grants.size()), DW'(8));
      for (int i = 0; i < grants.size() && i < 8; i++) check("fair_order", DW'(grants[i]), DW'(i % N));

      // Masked users 1 and 3 only, with a stalling sink.
      fixed_len = 0; en_mode = 1; p_ready = 60;
      for (int c = 0; c < 80; c++) step();

      // Fully random traffic, enables and back-pressure; CW=4 forces counter wrap.
      en_mode = 2; p_valid = 70; p_ready = 60;
      for (int c = 0; c < 3000; c++) step();

      // Asynchronous reset in the middle of a packet.
      en_mode = 0; p_valid = 100; p_ready = 100; fixed_len = 5;
      for (int u = 0; u < N; u++) new_packet(u);
      begin
         int budget = 0;
         while (!m_busy && budget < 50) begin step(); budget++; end
         check("busy_timeout", DW'(m_busy), DW'(1'b1));
      end
      step();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_m_tvalid", DW'(m_tvalid), DW'(1'b0));
      check("arst_s_tready", DW'(s_tready), DW'(0));
      check("arst_busy",     DW'(busy),     DW'(1'b0));
      check("arst_cur_user", DW'(cur_user), DW'(0));
      check("arst_pkt_cnt",  DW'(pkt_cnt),  DW'(0));
      model_reset();
      prev_busy = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      grants.delete();
      rec_grants = 1'b1;
      for (int c = 0; c < 8; c++) step();
      rec_grants = 1'b0;
      check("arst_first_grant", DW'(grants.size() > 0 ? grants[0] : -1), DW'(0));

      // Random traffic after reset.
      fixed_len = 0; en_mode = 2; p_valid = 80; p_ready = 70;
      for (int c = 0; c < 600; c++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mtpsa_user_arbiter.md
Name: mtpsa_user_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single user2 SDNet pipeline wrapper (256-bit AXIS data, 128-bit tuser) between NUM_USERS tenant ingress streams.
- Sits between the per-tenant classification/queueing stage and the user pipeline wrapper's s_axis port.
- Holds a grant for a whole packet (through tlast), honours a per-tenant enable mask, and keeps per-tenant forwarded-packet counters for the control plane.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width per stream; tkeep width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width per stream; passed through unmodified.
- NUM_USERS, 4, number of tenant input streams; range 2..8.
- USER_ID_WIDTH, 2, width of the grant index; equals clog2(NUM_USERS), minimum 1.
- CNT_WIDTH, 32, width of each per-tenant packet counter.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_USERS*C_AXIS_DATA_WIDTH  flattened; user i occupies slice i.
- s_axis_tkeep  in  NUM_USERS*C_AXIS_DATA_WIDTH/8  flattened tkeep.
- s_axis_tuser  in  NUM_USERS*C_AXIS_TUSER_WIDTH  flattened tuser.
- s_axis_tvalid  in  NUM_USERS  per-user valid.
- s_axis_tready  out  NUM_USERS  per-user ready.
- s_axis_tlast  in  NUM_USERS  per-user last.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  to user pipeline.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- user_enable  in  NUM_USERS  1 = user may win arbitration; sampled only in IDLE.
- busy  out  1  high while a packet is granted.
- cur_user  out  USER_ID_WIDTH  currently or last granted user.
- pkt_cnt  out  NUM_USERS*CNT_WIDTH  flattened per-user count of forwarded packets.

Behaviour:
- Reset (async assert, sync deassert on axis_resetn) sets:
  - state = IDLE, grant = 0, last_grant = NUM_USERS-1, so user 0 wins first.
  - all pkt_cnt = 0.
  - m_axis_tvalid = 0, all s_axis_tready = 0, busy = 0, cur_user = 0.
- FSM states are IDLE and BUSY.
- IDLE:
  - req = s_axis_tvalid & user_enable.
  - If req is nonzero, grant <= first set bit of req searching last_grant+1, last_grant+2, ... with modulo-NUM_USERS wrap. Then last_grant <= grant and go to BUSY.
  - If req is zero, stay in IDLE.
  - This costs one arbitration bubble per packet; no data moves in IDLE.
- BUSY:
  - m_axis_{tdata,tkeep,tuser,tlast,tvalid} = slice[grant] of the inputs (combinational mux from registered grant).
  - s_axis_tready[grant] = m_axis_tready; every other s_axis_tready = 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: pkt_cnt[grant] += 1 and go to IDLE.
- Outside BUSY: m_axis_tvalid = 0, m_axis_tlast = 0. m_axis_tdata/tkeep/tuser stay driven from slice[grant] and carry no meaning.
- busy = (state == BUSY). cur_user = grant.
- Latency: input to output is combinational in BUSY. Back-to-back packets from the same or different users are separated by exactly one idle cycle.
- Fairness: with all users requesting continuously, grants cycle 0,1,2,...,NUM_USERS-1,0,...
- Single-beat packet (tvalid and tlast on the first beat): one BUSY cycle when m_axis_tready = 1, then IDLE.
- Deasserting user_enable mid-packet has no effect: the current packet completes, and the mask applies from the next IDLE.
- A granted user dropping tvalid mid-packet holds BUSY: no timeout, and no other user is granted.
- m_axis_tready low stalls the granted user only; the grant is held.
- Counters wrap from 2^CNT_WIDTH-1 to 0 silently.
- Asynchronous reset mid-packet immediately forces m_axis_tvalid = 0 and s_axis_tready = 0. The truncated packet is not counted, and downstream recovery is the responsibility of the pipeline reset.
- Grant index arithmetic is modulo NUM_USERS, also for non-power-of-two NUM_USERS.

Test Plan:
- Reset release, user0 sends a 3-beat packet, m_axis_tready = 1 → first output beat 1 cycle after tvalid; 3 beats carry identical tdata/tuser; pkt_cnt[0] = 1; busy falls after the tlast beat.
- All 4 users hold continuous 2-beat packets, enable = 4'hF → output order 0,1,2,3,0,1,2,3; each pkt_cnt = 2 after 8 packets; exactly 1 idle cycle between packets.
- user_enable = 4'b1010, all users valid → only users 1 and 3 granted, alternating; pkt_cnt[0] = pkt_cnt[2] = 0; clearing enable[1] during a user1 packet still completes that packet.
- user2 granted for a 4-beat packet, m_axis_tready toggles 1,0,0,1,... → no beat lost or duplicated; s_axis_tready[2] mirrors m_axis_tready; other readies stay 0; user3 valid throughout is granted only after user2's tlast.
- Preload pkt_cnt[1] near wrap (force, or run 2^CNT_WIDTH packets with CNT_WIDTH = 4) → value 15 followed by 0 after the next user1 packet.
- Assert axis_resetn = 0 on beat 2 of a 5-beat user0 packet → m_axis_tvalid = 0 the same cycle; after release, pkt_cnt = 0, cur_user = 0, and user0 is again first to be granted.
